// File: rtl/secded_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : secded_pkg                                                      |
// | Purpose  : Shared constants and types for the Hamming(16,11) SECDED        |
// |            memory engine: decode status codes, mode encodings and the      |
// |            engine FSM state type.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package secded_pkg;

  // Decode status carried in result[15:14]
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_SGL = 2'b01;
  localparam logic [1:0] ST_DBL = 2'b10;

  // Operating mode, latched when a run is accepted
  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CAP   = 3'd3,
    S_CALC  = 3'd4,
    S_WR_LO = 3'd5,
    S_WR_HI = 3'd6,
    S_DONE  = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/secded_codec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : secded_codec                                                    |
// | Purpose  : Combinational Hamming(16,11) SECDED encoder / decoder.          |
// |            Codeword bit index equals Hamming position:                     |
// |            {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}.                  |
// | Ports    : mode   in  1   0 = decode, 1 = encode                           |
// |            raw    in  16  encode: raw[10:0] = d[11:1]; decode: codeword    |
// |            result out 16  encode: codeword;                                |
// |                           decode: {status, 3'b000, d[11:1]}               |
// |            sgl    out 1   single error corrected (decode only)             |
// |            dbl    out 1   double error detected (decode only)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module secded_codec
  import secded_pkg::*;
(
  input  logic        mode,
  input  logic [15:0] raw,
  output logic [15:0] result,
  output logic        sgl,
  output logic        dbl
);

  logic [11:1] w_d;
  logic [15:0] w_cw;
  logic [3:0]  w_syn;
  logic        w_par;
  logic [15:0] w_fix;
  logic [1:0]  w_status;
  logic [11:1] w_dec_d;

  always_comb begin
    // ---------------- encode ----------------
    w_d        = raw[10:0];
    w_cw       = '0;
    w_cw[15:9] = w_d[11:5];
    w_cw[7:5]  = w_d[4:2];
    w_cw[3]    = w_d[1];
    w_cw[8]    = ^w_d[11:5];
    w_cw[4]    = (^w_d[11:8]) ^ (^w_d[4:2]);
    w_cw[2]    = w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1];
    w_cw[1]    = w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1];
    w_cw[0]    = ^w_cw[15:1];

    // ---------------- decode ----------------
    // Syndrome is the XOR of the positions of every set bit; for a valid
    // codeword this cancels to zero, for a single flip it names the bit.
    w_syn = '0;
    for (int i = 1; i < 16; i++) begin
      if (raw[i]) w_syn = w_syn ^ 4'(i);
    end
    w_par    = ^raw;
    w_fix    = raw;
    w_status = ST_OK;
    if (w_par) begin
      // Odd overall parity: exactly one bit flipped; syn==0 means p0 itself.
      w_fix[w_syn] = ~raw[w_syn];
      w_status     = ST_SGL;
    end else if (w_syn != 4'd0) begin
      // Even parity but non-zero syndrome: two flips, not correctable.
      w_status = ST_DBL;
    end
    w_dec_d = {w_fix[15:9], w_fix[7:5], w_fix[3]};

    // ---------------- output select ----------------
    if (mode == MODE_ENC) begin
      result = w_cw;
      sgl    = 1'b0;
      dbl    = 1'b0;
    end else begin
      result = {w_status, 3'b000, w_dec_d};
      sgl    = (w_status == ST_SGL);
      dbl    = (w_status == ST_DBL);
    end
  end

endmodule
`default_nettype wire

// File: rtl/secded_mem_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : secded_mem_engine                                               |
// | Purpose  : DMA-style Hamming(16,11) SECDED engine. Reads NUM_WORDS 16-bit  |
// |            little-endian words from SRC_BASE in byte-wide sync RAM,        |
// |            encodes or decodes each one and writes the result to DST_BASE.  |
// |            Six cycles per word; each word is fully read before written.    |
// | Ports    : clk, reset (async, active-high)                                 |
// |            req         in   start request (accepted in IDLE/DONE)          |
// |            mode        in   0 = decode, 1 = encode (latched on accept)     |
// |            done        out  run complete, held in DONE                     |
// |            busy        out  high outside IDLE/DONE                         |
// |            mem_addr    out  byte address                                   |
// |            mem_rd_data in   read byte, valid the cycle after mem_addr      |
// |            mem_wr_en   out  byte write strobe                              |
// |            mem_wr_data out  write byte                                     |
// |            single_cnt  out  corrected single errors this run (saturating)  |
// |            double_cnt  out  detected double errors this run (saturating)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module secded_mem_engine
  import secded_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic [CNT_W-1:0]  single_cnt,
  output logic [CNT_W-1:0]  double_cnt
);

  localparam logic [ADDR_W-1:0] c_src_base = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] c_dst_base = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic              r_mode;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_lo;
  logic [7:0]        r_hi;
  logic [15:0]       r_result;
  logic [CNT_W-1:0]  r_single;
  logic [CNT_W-1:0]  r_double;

  logic              w_start;
  logic              w_last;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;
  logic [15:0]       w_codec_result;
  logic              w_sgl;
  logic              w_dbl;

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign w_src_addr = c_src_base + (r_idx << 1);
  assign w_dst_addr = c_dst_base + (r_idx << 1);
  assign w_last     = (r_idx == c_last_idx);
  assign w_start    = req && ((r_state == S_IDLE) || (r_state == S_DONE));

  secded_codec u_codec (
    .mode   (r_mode),
    .raw    ({r_hi, r_lo}),
    .result (w_codec_result),
    .sgl    (w_sgl),
    .dbl    (w_dbl)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------- next state and memory-side outputs ----------------
  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) w_next = S_RD_LO;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (req) w_next = S_RD_LO;
      end
      S_RD_LO: begin
        mem_addr = w_src_addr;
        w_next   = S_RD_HI;
      end
      S_RD_HI: begin
        mem_addr = w_src_addr + c_one;
        w_next   = S_CAP;
      end
      S_CAP:  w_next = S_CALC;
      S_CALC: w_next = S_WR_LO;
      S_WR_LO: begin
        mem_addr    = w_dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_result[7:0];
        w_next      = S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr    = w_dst_addr + c_one;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_result[15:8];
        w_next      = w_last ? S_DONE : S_RD_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_DEC;
      r_idx    <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_result <= '0;
      r_single <= '0;
      r_double <= '0;
    end else begin
      if (w_start) begin
        r_mode   <= mode;
        r_idx    <= '0;
        r_single <= '0;
        r_double <= '0;
      end
      case (r_state)
        // Read data lags the address by one cycle.
        S_RD_HI: r_lo <= mem_rd_data;
        S_CAP:   r_hi <= mem_rd_data;
        S_CALC: begin
          r_result <= w_codec_result;
          if (w_sgl && (r_single != '1)) r_single <= r_single + CNT_W'(1);
          if (w_dbl && (r_double != '1)) r_double <= r_double + CNT_W'(1);
        end
        S_WR_HI: begin
          if (!w_last) r_idx <= r_idx + c_one;
        end
        default: ;
      endcase
    end
  end

  assign single_cnt = r_single;
  assign double_cnt = r_double;

endmodule
`default_nettype wire

// File: tb/tb_secded_mem_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_secded_mem_engine                                            |
// | Purpose  : Self-checking bench for secded_mem_engine and secded_codec.     |
// |            Reference model builds codewords from Hamming position rules.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_secded_mem_engine;
  import secded_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // single-word engine
  logic       req1, mode1, done1, busy1, we1;
  logic [7:0] addr1, rd1, wd1, sc1, dc1;
  // fifteen-word engine (default parameters)
  logic       req15, mode15, done15, busy15, we15;
  logic [7:0] addr15, rd15, wd15, sc15, dc15;
  // standalone codec
  logic        cmode, csgl, cdbl;
  logic [15:0] craw, cres;

  logic [7:0] mem1  [256];
  logic [7:0] mem15 [256];
  logic       tb_we;
  int         tb_sel;
  logic [7:0] tb_addr, tb_data;

  int checks = 0;
  int errors = 0;

  secded_mem_engine #(.NUM_WORDS(1), .SRC_BASE(30), .DST_BASE(0), .ADDR_W(8), .CNT_W(8)) u_one (
    .clk(clk), .reset(rst), .req(req1), .mode(mode1), .done(done1), .busy(busy1),
    .mem_addr(addr1), .mem_rd_data(rd1), .mem_wr_en(we1), .mem_wr_data(wd1),
    .single_cnt(sc1), .double_cnt(dc1));

  secded_mem_engine u_dut (
    .clk(clk), .reset(rst), .req(req15), .mode(mode15), .done(done15), .busy(busy15),
    .mem_addr(addr15), .mem_rd_data(rd15), .mem_wr_en(we15), .mem_wr_data(wd15),
    .single_cnt(sc15), .double_cnt(dc15));

  secded_codec u_codec (.mode(cmode), .raw(craw), .result(cres), .sgl(csgl), .dbl(cdbl));

  // Byte-wide synchronous RAMs; bench preload port only used while engines idle.
  always @(posedge clk) begin
    rd1 <= mem1[addr1];
    if (we1) mem1[addr1] <= wd1;
    else if (tb_we && tb_sel == 1) mem1[tb_addr] <= tb_data;
  end
  always @(posedge clk) begin
    rd15 <= mem15[addr15];
    if (we15) mem15[addr15] <= wd15;
    else if (tb_we && tb_sel == 15) mem15[tb_addr] <= tb_data;
  end

  // ---------------- reference model ----------------
  // Data bits fill the non-power-of-two positions 3..15 in order; parity bit
  // at position p covers every position whose index has bit p set.
  function automatic logic [15:0] m_enc(input logic [10:0] d);
    logic [15:0] cw;
    logic        b;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      b = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if (((pos & p) != 0) && (pos != p)) b = b ^ cw[pos];
      end
      cw[p] = b;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] m_extract(input logic [15:0] cw);
    logic [10:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int pos = 3; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  // Random word with k distinct bit flips and its expected decode output.
  task automatic make_dec(input int k, output logic [15:0] raw, output logic [15:0] exp);
    logic [10:0] d;
    int          a, b;
    d   = 11'($urandom);
    raw = m_enc(d);
    a   = int'($urandom_range(0, 15));
    b   = (a + int'($urandom_range(1, 15))) % 16;
    if (k >= 1) raw[a] = ~raw[a];
    if (k == 2) raw[b] = ~raw[b];
    case (k)
      0:       exp = {5'b00000, d};
      1:       exp = {2'b01, 3'b000, d};
      default: exp = {2'b10, 3'b000, m_extract(raw)};
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int which, input int a, input logic [7:0] v);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_sel  = which;
    tb_addr = 8'(a);
    tb_data = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Start a run, then count edges until done; pulses req and flips mode mid-run.
  task automatic run(input int which, input logic m, output int cyc);
    logic dn, bz;
    @(negedge clk);
    if (which == 1) begin req1 = 1'b1; mode1 = m; end
    else begin req15 = 1'b1; mode15 = m; end
    @(posedge clk);
    cyc = 0;
    #1;
    req1 = 1'b0; req15 = 1'b0; mode1 = ~m; mode15 = ~m;
    while (cyc < 400) begin
      @(negedge clk);
      dn = (which == 1) ? done1 : done15;
      bz = (which == 1) ? busy1 : busy15;
      if (dn) break;
      if (cyc == 1) check("busy_mid", 32'(bz), 32'd1);
      if (cyc == 2) begin
        if (which == 1) req1 = 1'b1; else req15 = 1'b1;
      end else begin
        req1 = 1'b0; req15 = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    req1 = 1'b0; req15 = 1'b0;
  endtask

  task automatic dir1(input string tag, input logic m, input logic [15:0] raw,
                      input logic [15:0] exp, input int es, input int ed);
    int cyc;
    poke(1, 30, raw[7:0]);
    poke(1, 31, raw[15:8]);
    poke(1, 0, ~exp[7:0]);
    poke(1, 1, ~exp[15:8]);
    run(1, m, cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'd6);
    check({tag, "_word"}, {16'h0, mem1[1], mem1[0]}, {16'h0, exp});
    check({tag, "_single"}, 32'(sc1), 32'(es));
    check({tag, "_double"}, 32'(dc1), 32'(ed));
    check({tag, "_busy_end"}, 32'(busy1), 32'd0);
  endtask

  logic [15:0] exp_w [15];
  int          n_sgl, n_dbl;

  task automatic prep15(input logic m);
    logic [15:0] raw, exp;
    logic [10:0] d;
    int          k;
    n_sgl = 0;
    n_dbl = 0;
    for (int i = 0; i < 15; i++) begin
      if (m == MODE_ENC) begin
        d   = 11'($urandom);
        raw = {5'($urandom), d};
        exp = m_enc(d);
      end else begin
        k = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 0 : int'($urandom_range(0, 2));
        make_dec(k, raw, exp);
        if (k == 1) n_sgl++;
        if (k == 2) n_dbl++;
      end
      exp_w[i] = exp;
      poke(15, 30 + 2 * i, raw[7:0]);
      poke(15, 31 + 2 * i, raw[15:8]);
    end
  endtask

  task automatic check15(input string tag);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("%s_w%0d", tag, i), {16'h0, mem15[2 * i + 1], mem15[2 * i]}, {16'h0, exp_w[i]});
    end
    check({tag, "_single"}, 32'(sc15), 32'(n_sgl));
    check({tag, "_double"}, 32'(dc15), 32'(n_dbl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    logic [15:0] raw, exp;
    int          k;

    rst = 1'b1; req1 = 1'b0; mode1 = 1'b0; req15 = 1'b0; mode15 = 1'b0;
    tb_we = 1'b0; tb_sel = 0; tb_addr = '0; tb_data = '0;
    cmode = 1'b0; craw = '0;
    for (int i = 0; i < 256; i++) begin mem1[i] = 8'h00; mem15[i] = 8'h00; end
    repeat (3) @(negedge clk);

    // reset state
    check("rst_done", 32'(done15), 32'd0);
    check("rst_busy", 32'(busy15), 32'd0);
    check("rst_wren", 32'(we15), 32'd0);
    check("rst_addr", 32'(addr15), 32'd0);
    check("rst_single", 32'(sc15), 32'd0);
    check("rst_double", 32'(dc15), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    rst = 1'b0;

    // standalone codec against the model
    for (int i = 0; i < 40; i++) begin
      cmode = (i % 2 == 0) ? MODE_ENC : MODE_DEC;
      if (cmode == MODE_ENC) begin
        craw = 16'($urandom);
        #1;
        check("codec_enc", {16'h0, cres}, {16'h0, m_enc(craw[10:0])});
        check("codec_enc_flags", {30'h0, csgl, cdbl}, 32'd0);
      end else begin
        k = i % 3;
        make_dec(k, raw, exp);
        craw = raw;
        #1;
        check("codec_dec", {16'h0, cres}, {16'h0, exp});
        check("codec_dec_flags", {30'h0, csgl, cdbl}, {30'h0, k == 1, k == 2});
      end
    end

    // directed single-word runs
    dir1("enc_5a5", MODE_ENC, 16'h05A5, 16'hB44B, 0, 0);
    dir1("enc_5a5_junk_hi", MODE_ENC, 16'hF5A5, 16'hB44B, 0, 0);
    dir1("dec_clean", MODE_DEC, 16'hB44B, 16'h05A5, 0, 0);
    dir1("dec_bit9", MODE_DEC, 16'hB44B ^ 16'h0200, 16'h45A5, 1, 0);
    dir1("dec_bit0", MODE_DEC, 16'hB44B ^ 16'h0001, 16'h45A5, 1, 0);
    dir1("dec_dbl_3_12", MODE_DEC, 16'hB44B ^ 16'h1008, 16'h8524, 0, 1);
    check("done_held", 32'(done1), 32'd1);

    // full fifteen-word random decode
    prep15(MODE_DEC);
    run(15, MODE_DEC, cyc);
    check("dec15_cycles", 32'(cyc), 32'd90);
    check15("dec15");

    // full fifteen-word random encode
    prep15(MODE_ENC);
    run(15, MODE_ENC, cyc);
    check("enc15_cycles", 32'(cyc), 32'd90);
    check15("enc15");

    // reset in the middle of word 3, then a clean rerun
    prep15(MODE_DEC);
    @(negedge clk);
    req15 = 1'b1; mode15 = MODE_DEC;
    @(posedge clk);
    #1 req15 = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("pre_rst_single", 32'(sc15), 32'd1);
    check("pre_rst_double", 32'(dc15), 32'd1);
    check("pre_rst_busy", 32'(busy15), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy15), 32'd0);
    check("mid_rst_done", 32'(done15), 32'd0);
    check("mid_rst_single", 32'(sc15), 32'd0);
    check("mid_rst_double", 32'(dc15), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prep15(MODE_DEC);
    run(15, MODE_DEC, cyc);
    check("rerun_cycles", 32'(cyc), 32'd90);
    check15("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
